// File: rtl/vga_pkg.sv
// Shared VGA/text-layer constants and types used by the text sequencer.
package vga_pkg;

    // Blank character code emitted for hidden or out-of-range cells.
    localparam logic [6:0] SPACE = 7'h20;

    // Characters per text page (16 cols x 4 rows).
    localparam int unsigned TXT_CHARS = 64;

    typedef enum logic {
        S_REVEAL = 1'b0,
        S_FULL   = 1'b1
    } txt_seq_state_t;

endpackage

// File: rtl/game_txt_seq_tick.sv
// game_txt_tick: prescaler for the typewriter reveal, one-cycle tick every DIV clocks.
// Only instantiated when GAME_TXT_REVEAL_EN is defined.
module game_txt_tick #(
    parameter int unsigned DIV = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    // Next count: wrap after DIV cycles, restart from zero on clr.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_txt_seq.sv
// game_txt_seq: text-page sequencer between the char-position generator and the
// char renderer. Latches page requests, applies them at frame start, and masks
// not-yet-revealed characters. Typewriter reveal is enabled by GAME_TXT_REVEAL_EN;
// without it every applied page is shown in full.
module game_txt_seq
    import vga_pkg::*;
#(
    parameter int unsigned NPAGES   = 4,
    parameter int unsigned CHARS    = TXT_CHARS,
    parameter int unsigned TICK_DIV = 2_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      next_pg,
    input  logic                      prev_pg,
    input  logic                      restart,
    input  logic [7:0]                char_xy,
    input  logic [NPAGES*7-1:0]       rom_code,
    output logic [6:0]                char_code,
    output logic [$clog2(NPAGES)-1:0] page_sel,
    output logic                      reveal_done
);

    localparam int unsigned PW = $clog2(NPAGES);
    localparam int unsigned CW = $clog2(CHARS + 1);
    localparam int unsigned MW = (CW > 8) ? CW : 8;

    if (NPAGES < 2) begin : g_chk_npages
        $error("game_txt_seq: NPAGES must be >= 2");
    end
    if (TICK_DIV < 1) begin : g_chk_div
        $error("game_txt_seq: TICK_DIV must be >= 1");
    end

    txt_seq_state_t state_q;
    logic [CW-1:0]  reveal_cnt_q;
    logic           reveal_done_q;
    logic [PW-1:0]  page_sel_q;
    logic [PW-1:0]  pend_pg_q;
    logic [PW-1:0]  pend_pg_d;
    logic [PW-1:0]  pend_base;
    logic           pend_valid_q;
    logic           pend_valid_d;
    logic           apply;
    logic [7:0]     xy_d1_q;
    logic [6:0]     char_code_q;
    logic [6:0]     sel_code;

`ifdef GAME_TXT_REVEAL_EN
    logic tick;

    game_txt_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (apply),
        .tick (tick)
    );
`endif

    // Request accumulation; a request in the frame_start cycle joins the apply.
    always_comb begin
        pend_base = pend_valid_q ? pend_pg_q : page_sel_q;
        pend_pg_d = pend_base;
        if (next_pg && !prev_pg) begin
            pend_pg_d = (pend_base == PW'(NPAGES - 1)) ? '0 : pend_base + PW'(1);
        end else if (prev_pg && !next_pg) begin
            pend_pg_d = (pend_base == '0) ? PW'(NPAGES - 1) : pend_base - PW'(1);
        end
        pend_valid_d = pend_valid_q | (next_pg ^ prev_pg) | restart;
        apply        = frame_start & pend_valid_d;
    end

    // Pending-request latch, cleared when the request is applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_pg_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            pend_pg_q    <= pend_pg_d;
            pend_valid_q <= apply ? 1'b0 : pend_valid_d;
        end
    end

    // Page apply, reveal FSM and saturating reveal counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REVEAL;
            reveal_cnt_q  <= '0;
            reveal_done_q <= 1'b0;
            page_sel_q    <= '0;
        end else if (apply) begin
            page_sel_q <= pend_pg_d;
`ifdef GAME_TXT_REVEAL_EN
            state_q       <= S_REVEAL;
            reveal_cnt_q  <= '0;
            reveal_done_q <= 1'b0;
`else
            state_q       <= S_FULL;
            reveal_cnt_q  <= CW'(CHARS);
            reveal_done_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_REVEAL: begin
`ifdef GAME_TXT_REVEAL_EN
                    if (tick) begin
                        reveal_cnt_q <= reveal_cnt_q + CW'(1);
                        if (reveal_cnt_q == CW'(CHARS - 1)) begin
                            state_q       <= S_FULL;
                            reveal_done_q <= 1'b1;
                        end
                    end
`else
                    state_q       <= S_FULL;
                    reveal_cnt_q  <= CW'(CHARS);
                    reveal_done_q <= 1'b1;
`endif
                end
                default: ; // S_FULL: frozen until the next apply
            endcase
        end
    end

    // Select the active page's ROM output.
    always_comb begin
        sel_code = '0;
        for (int unsigned p = 0; p < NPAGES; p++) begin
            if (page_sel_q == PW'(p)) begin
                sel_code = rom_code[7*p +: 7];
            end
        end
    end

    // Two-stage pipeline: align char_xy with ROM latency, then mask and register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xy_d1_q     <= '0;
            char_code_q <= SPACE;
        end else begin
            xy_d1_q     <= char_xy;
            char_code_q <= (MW'(xy_d1_q) < MW'(reveal_cnt_q)) ? sel_code : SPACE;
        end
    end

    assign char_code   = char_code_q;
    assign page_sel    = page_sel_q;
    assign reveal_done = reveal_done_q;

endmodule

// File: tb/tb_game_txt_seq.sv
// Self-checking bench for game_txt_seq against a cycle-count based reference model.
module tb_game_txt_seq;

    localparam int unsigned NP  = 4;
    localparam int unsigned CH  = 64;
    localparam int unsigned DIV = 4;
    localparam int unsigned SP  = 32'h20;
`ifdef GAME_TXT_REVEAL_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            frame_start = 1'b0;
    logic            next_pg = 1'b0;
    logic            prev_pg = 1'b0;
    logic            restart = 1'b0;
    logic [7:0]      char_xy = '0;
    logic [NP*7-1:0] rom_code;
    logic [6:0]      char_code;
    logic [1:0]      page_sel;
    logic            reveal_done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state: page, pending request, clocks since last apply.
    int unsigned m_page, m_pend, m_cycles, m_xy_prev;
    bit          m_pend_valid, m_nr_full;
    int unsigned exp_code, exp_page, exp_done;

    always #5 clk = ~clk;

    game_txt_seq #(
        .NPAGES   (NP),
        .CHARS    (CH),
        .TICK_DIV (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .next_pg     (next_pg),
        .prev_pg     (prev_pg),
        .restart     (restart),
        .char_xy     (char_xy),
        .rom_code    (rom_code),
        .char_code   (char_code),
        .page_sel    (page_sel),
        .reveal_done (reveal_done)
    );

    function automatic int unsigned rom_fn(input int unsigned p, input int unsigned xy);
        return ((p % 4) << 5) | 16 | (xy & 15);
    endfunction

    // Stub ROMs with one clock of latency.
    always @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            rom_code[7*p +: 7] <= 7'(rom_fn(p, char_xy));
        end
    end

    function automatic int unsigned model_rev();
        if (REV_EN) return (m_cycles / DIV >= CH) ? CH : m_cycles / DIV;
        return m_nr_full ? CH : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int unsigned base;
        if (rst) begin
            m_xy_prev = char_xy;
            return;
        end
        exp_code  = (m_xy_prev < model_rev()) ? rom_fn(m_page, m_xy_prev) : SP;
        m_xy_prev = char_xy;
        base = m_pend_valid ? m_pend : m_page;
        if (next_pg && !prev_pg) begin
            m_pend = (base + 1) % NP;
            m_pend_valid = 1'b1;
        end else if (prev_pg && !next_pg) begin
            m_pend = (base + NP - 1) % NP;
            m_pend_valid = 1'b1;
        end
        if (restart && !m_pend_valid) begin
            m_pend = m_page;
            m_pend_valid = 1'b1;
        end
        m_nr_full = 1'b1;
        if (frame_start && m_pend_valid) begin
            m_page = m_pend;
            m_pend_valid = 1'b0;
            m_cycles = 0;
        end else begin
            m_cycles++;
        end
        exp_page = m_page;
        exp_done = (model_rev() == CH) ? 1 : 0;
    endtask

    // One clock: model update at the edge, compare at the falling edge, drop pulses.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("cyc_code", 32'(char_code), exp_code);
        chk("cyc_page", 32'(page_sel), exp_page);
        chk("cyc_done", 32'(reveal_done), exp_done);
        frame_start = 1'b0;
        next_pg     = 1'b0;
        prev_pg     = 1'b0;
        restart     = 1'b0;
    endtask

    task automatic do_reset(input int unsigned hold);
        rst = 1'b1;
        #1;
        chk("rst_page", 32'(page_sel), 0);
        chk("rst_code", 32'(char_code), SP);
        chk("rst_done", 32'(reveal_done), 0);
        m_page = 0; m_pend = 0; m_pend_valid = 1'b0; m_cycles = 0; m_nr_full = 1'b0;
        exp_code = SP; exp_page = 0; exp_done = 0;
        for (int unsigned i = 0; i < hold; i++) step();
        rst = 1'b0;
    endtask

    task automatic rand_cycle();
        char_xy     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, CH - 1));
        next_pg     = ($urandom_range(0, 63) == 0);
        prev_pg     = ($urandom_range(0, 63) == 0);
        restart     = ($urandom_range(0, 127) == 0);
        frame_start = ($urandom_range(0, 299) == 0);
        step();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset(3);

        // Sweep right after reset, then let the reveal complete.
        for (int i = 0; i < CH; i++) begin
            char_xy = 8'(i);
            step();
        end
        for (int unsigned i = 0; i < CH * DIV; i++) begin
            char_xy = 8'($urandom_range(0, CH - 1));
            step();
        end
        chk("done_after_full", 32'(reveal_done), 1);
        for (int i = 0; i < CH; i++) begin
            char_xy = 8'(i);
            step();
        end
        char_xy = 8'h25; step();
        char_xy = 8'h41; step();
        chk("full_unmasked", 32'(char_code), rom_fn(0, 8'h25));
        char_xy = 8'h00; step();
        chk("xy_ge_chars", 32'(char_code), SP);

        // Wrap both directions.
        prev_pg = 1'b1; frame_start = 1'b1; step();
        chk("prev_wrap_0to3", 32'(page_sel), 3);
        chk("apply_done", 32'(reveal_done), REV_EN ? 0 : 1);
        next_pg = 1'b1; frame_start = 1'b1; step();
        chk("next_wrap_3to0", 32'(page_sel), 0);

        // Mask boundary around reveal_cnt = 6.
        for (int i = 0; i < 200 && m_cycles != 6 * DIV; i++) begin
            char_xy = 8'hF0;
            step();
        end
        char_xy = 8'h05; step();
        char_xy = 8'h06; step();
        chk("xy05_rev6", 32'(char_code), rom_fn(0, 5));
        char_xy = 8'hF0; step();
        chk("xy06_rev6", 32'(char_code), REV_EN ? SP : rom_fn(0, 6));

        // Accumulation and cancellation.
        next_pg = 1'b1; step();
        next_pg = 1'b1; step();
        frame_start = 1'b1; step();
        chk("next_x2", 32'(page_sel), 2);
        next_pg = 1'b1; prev_pg = 1'b1; step();
        frame_start = 1'b1; step();
        chk("both_ignored", 32'(page_sel), 2);

        // Request held across a long frame.
        next_pg = 1'b1; step();
        for (int i = 0; i < 1000; i++) begin
            char_xy = 8'($urandom);
            step();
        end
        chk("no_fs_hold", 32'(page_sel), 2);
        frame_start = 1'b1; step();
        chk("deferred_apply", 32'(page_sel), 3);

        // Restart on the same page.
        for (int i = 0; i < 100; i++) begin
            char_xy = 8'($urandom_range(0, CH - 1));
            step();
        end
        restart = 1'b1; step();
        for (int i = 0; i < 10; i++) step();
        frame_start = 1'b1; step();
        chk("restart_page", 32'(page_sel), 3);
        chk("restart_done", 32'(reveal_done), REV_EN ? 0 : 1);
        char_xy = 8'h00; step();
        step();
        chk("restart_mask", 32'(char_code), REV_EN ? SP : rom_fn(3, 0));

        // Reset in the middle of a reveal.
        for (int i = 0; i < 400 && model_rev() != 30; i++) begin
            char_xy = 8'($urandom_range(0, CH - 1));
            step();
        end
        do_reset(2);
        char_xy = 8'h00; step();
        chk("post_rst_code", 32'(char_code), SP);

        // Random traffic.
        for (int i = 0; i < 4000; i++) rand_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
